mem_stage: RTL and testbench

- Memory-access stage of the 5-stage RV64 pipeline. Sits between the EX/MEM register and the MEM/WB register.
- Takes the executed instruction and drives the data bus for loads and stores.
- Aligns and extends load data, then produces the next value for the MEM/WB register.
- Asserts a stall while a bus transaction is outstanding.

---
 rtl/mem_stage_pkg.sv | 56 +++++
 rtl/mem_align.sv | 51 +++++
 rtl/mem_stage.sv | 148 ++++++++++++++
 tb/tb_mem_stage.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_stage_pkg.sv
// Shared types for the memory-access stage: pipeline bundles, data-bus
// request/response records and load/store size encodings.
package mem_stage_pkg;

    localparam int unsigned BUS_W = 64;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_D  = 3'b011;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;
    localparam logic [2:0] F3_WU = 3'b110;

    localparam logic [1:0] SIZE_B = 2'd0;
    localparam logic [1:0] SIZE_H = 2'd1;
    localparam logic [1:0] SIZE_W = 2'd2;
    localparam logic [1:0] SIZE_D = 2'd3;

    typedef enum logic [1:0] {IDLE, WAIT, DONE} mem_state_t;

    typedef struct packed {
        logic             valid;
        logic [BUS_W-1:0] pc;
        logic [BUS_W-1:0] alu;
        logic [BUS_W-1:0] wdata;
        logic             memread;
        logic             memwrite;
        logic [2:0]       funct3;
        logic [4:0]       rd;
        logic             regwrite;
    } execute_data_t;

    typedef struct packed {
        logic             valid;
        logic [BUS_W-1:0] pc;
        logic [BUS_W-1:0] result;
        logic [4:0]       rd;
        logic             regwrite;
        logic             misalign;
    } memory_data_t;

    typedef struct packed {
        logic             valid;
        logic [BUS_W-1:0] addr;
        logic [2:0]       size;
        logic [7:0]       strobe;
        logic [BUS_W-1:0] data;
    } dbus_req_t;

    typedef struct packed {
        logic             dataOk;
        logic [BUS_W-1:0] data;
    } dbus_resp_t;

endpackage

// File: rtl/mem_align.sv
// Byte-lane steering for the data bus: store strobes/data, load
// shift-and-extend, and natural-alignment check. Purely combinational.
module mem_align
    import mem_stage_pkg::*;
(
    input  logic [2:0]       lane,
    input  logic [2:0]       funct3,
    input  logic [BUS_W-1:0] wdata,
    input  logic [BUS_W-1:0] rdata,
    output logic [1:0]       size,
    output logic [7:0]       strobe,
    output logic [BUS_W-1:0] storeData,
    output logic [BUS_W-1:0] loadData,
    output logic             misalign
);

    logic [BUS_W-1:0] shifted;
    logic [7:0]       mask;

    assign size      = funct3[1:0];
    assign storeData = wdata << {lane, 3'b000};
    assign shifted   = rdata >> {lane, 3'b000};
    assign strobe    = mask << lane;

    always_comb begin
        mask     = '0;
        misalign = 1'b0;
        case (size)
            SIZE_B: begin mask = 8'h01; misalign = 1'b0;             end
            SIZE_H: begin mask = 8'h03; misalign = lane[0];          end
            SIZE_W: begin mask = 8'h0F; misalign = |lane[1:0];       end
            SIZE_D: begin mask = 8'hFF; misalign = |lane;            end
            default: begin mask = '0;   misalign = 1'b0;             end
        endcase
    end

    always_comb begin
        loadData = shifted;
        case (funct3)
            F3_B:  loadData = {{56{shifted[7]}},  shifted[7:0]};
            F3_H:  loadData = {{48{shifted[15]}}, shifted[15:0]};
            F3_W:  loadData = {{32{shifted[31]}}, shifted[31:0]};
            F3_D:  loadData = shifted;
            F3_BU: loadData = {56'b0, shifted[7:0]};
            F3_HU: loadData = {48'b0, shifted[15:0]};
            F3_WU: loadData = {32'b0, shifted[31:0]};
            default: loadData = shifted;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// RV64 memory-access stage: issues data-bus requests for loads/stores,
// stalls the pipe while a transaction is outstanding, and builds MEM/WB data.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int unsigned XLEN = 64
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    input  logic [XLEN-1:0] in_pc,
    input  logic [XLEN-1:0] in_alu,
    input  logic [XLEN-1:0] in_wdata,
    input  logic            in_memread,
    input  logic            in_memwrite,
    input  logic [2:0]      in_funct3,
    input  logic [4:0]      in_rd,
    input  logic            in_regwrite,
    output logic            dreq_valid,
    output logic [XLEN-1:0] dreq_addr,
    output logic [2:0]      dreq_size,
    output logic [7:0]      dreq_strobe,
    output logic [XLEN-1:0] dreq_data,
    input  logic            dresp_data_ok,
    input  logic [XLEN-1:0] dresp_data,
    output logic            out_valid,
    output logic [XLEN-1:0] out_pc,
    output logic [XLEN-1:0] out_result,
    output logic [4:0]      out_rd,
    output logic            out_regwrite,
    output logic            out_misalign,
    output logic            stall_m
);

    execute_data_t    ex;
    dbus_resp_t       resp;
    dbus_req_t        reqNow, reqQ, req;
    memory_data_t     mo;
    mem_state_t       state;
    logic [BUS_W-1:0] rdataQ;

    logic [1:0]       size;
    logic [7:0]       strobe;
    logic [BUS_W-1:0] storeData, loadData;
    logic             misalign, isMem, issue, rdNonZero;

    assign ex = '{valid: in_valid, pc: in_pc, alu: in_alu, wdata: in_wdata,
                  memread: in_memread, memwrite: in_memwrite, funct3: in_funct3,
                  rd: in_rd, regwrite: in_regwrite};
    assign resp = '{dataOk: dresp_data_ok, data: dresp_data};

    mem_align u_align (
        .lane      (ex.alu[2:0]),
        .funct3    (ex.funct3),
        .wdata     (ex.wdata),
        .rdata     (rdataQ),
        .size      (size),
        .strobe    (strobe),
        .storeData (storeData),
        .loadData  (loadData),
        .misalign  (misalign)
    );

    assign isMem     = ex.valid & (ex.memread | ex.memwrite);
    assign issue     = (state == IDLE) & isMem & ~misalign;
    assign rdNonZero = |ex.rd;

    always_comb begin
        reqNow        = '0;
        reqNow.valid  = issue;
        reqNow.addr   = ex.alu;
        reqNow.size   = {1'b0, size};
        reqNow.strobe = ex.memwrite ? strobe : '0;
        reqNow.data   = ex.memwrite ? storeData : '0;
    end

    // Request is snapshotted at issue so WAIT drives it from registers,
    // keeping the bus contract independent of upstream freeze behaviour.
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            rdataQ <= '0;
            reqQ   <= '0;
        end else begin
            case (state)
                IDLE: if (issue) begin
                    state <= WAIT;
                    reqQ  <= reqNow;
                end
                WAIT: if (resp.dataOk) begin
                    state  <= DONE;
                    rdataQ <= resp.data;
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        req     = '0;
        mo      = '0;
        stall_m = 1'b0;
        if (!reset) begin
            case (state)
                IDLE: begin
                    if (issue) begin
                        req     = reqNow;
                        stall_m = 1'b1;
                    end else begin
                        mo.valid    = ex.valid;
                        mo.pc       = ex.pc;
                        mo.result   = ex.alu;
                        mo.rd       = ex.rd;
                        mo.misalign = isMem & misalign;
                        mo.regwrite = ex.valid & ex.regwrite & rdNonZero
                                      & ~ex.memwrite & ~mo.misalign;
                    end
                end
                WAIT: begin
                    req     = reqQ;
                    stall_m = 1'b1;
                end
                DONE: begin
                    mo.valid    = 1'b1;
                    mo.pc       = ex.pc;
                    mo.result   = ex.memread ? loadData : ex.alu;
                    mo.rd       = ex.rd;
                    mo.regwrite = ex.regwrite & rdNonZero & ~ex.memwrite;
                end
                default: ;
            endcase
        end
    end

    assign dreq_valid   = req.valid;
    assign dreq_addr    = req.addr;
    assign dreq_size    = req.size;
    assign dreq_strobe  = req.strobe;
    assign dreq_data    = req.data;
    assign out_valid    = mo.valid;
    assign out_pc       = mo.pc;
    assign out_result   = mo.result;
    assign out_rd       = mo.rd;
    assign out_regwrite = mo.regwrite;
    assign out_misalign = mo.misalign;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: byte-level reference model for loads/stores,
// per-cycle output comparison, and literal pins for the key scenarios.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid, in_memread, in_memwrite, in_regwrite;
    logic [63:0] in_pc, in_alu, in_wdata;
    logic [2:0]  in_funct3;
    logic [4:0]  in_rd;
    logic        dreq_valid;
    logic [63:0] dreq_addr, dreq_data;
    logic [2:0]  dreq_size;
    logic [7:0]  dreq_strobe;
    logic        dresp_data_ok;
    logic [63:0] dresp_data;
    logic        out_valid, out_regwrite, out_misalign, stall_m;
    logic [63:0] out_pc, out_result;
    logic [4:0]  out_rd;

    always #5 clk = ~clk;

    mem_stage #(.XLEN(64)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_pc(in_pc), .in_alu(in_alu), .in_wdata(in_wdata),
        .in_memread(in_memread), .in_memwrite(in_memwrite), .in_funct3(in_funct3),
        .in_rd(in_rd), .in_regwrite(in_regwrite),
        .dreq_valid(dreq_valid), .dreq_addr(dreq_addr), .dreq_size(dreq_size),
        .dreq_strobe(dreq_strobe), .dreq_data(dreq_data),
        .dresp_data_ok(dresp_data_ok), .dresp_data(dresp_data),
        .out_valid(out_valid), .out_pc(out_pc), .out_result(out_result),
        .out_rd(out_rd), .out_regwrite(out_regwrite), .out_misalign(out_misalign),
        .stall_m(stall_m)
    );

    int unsigned nChecks = 0;
    int unsigned nFails  = 0;
    logic        chk = 1'b0;

    logic        eDreqValid, eDataChk, eOutValid, eRegwrite, eMisalign, eStall;
    logic [63:0] eAddr, eData, ePc, eResult;
    logic [2:0]  eSize;
    logic [7:0]  eStrobe;
    logic [4:0]  eRd;

    int unsigned stallTotal = 0;
    int unsigned validTotal = 0;
    logic [63:0] lastResult, lastReqData;
    logic [7:0]  lastStrobe;
    logic [2:0]  lastSize;
    logic        lastRegwrite, lastMisalign;
    logic [63:0] pc = 64'h8000_0000;

    typedef struct {
        logic [2:0]  f3;
        logic        wr;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [63:0] rdata;
        logic [4:0]  rd;
        logic        rw;
        int unsigned waits;
    } vec_t;
    vec_t vecs[9];

    function automatic logic [63:0] refLoad(logic [63:0] d, logic [2:0] lane, logic [2:0] f3);
        int unsigned n = 1 << f3[1:0];
        logic [63:0] v = '0;
        for (int unsigned i = 0; i < n; i++)
            if (lane + i < 8) v[8*i +: 8] = d[8*(lane+i) +: 8];
        if (!f3[2] && n < 8 && v[8*n-1])
            for (int unsigned b = 8*n; b < 64; b++) v[b] = 1'b1;
        return v;
    endfunction

    function automatic logic [7:0] refStrobe(logic [2:0] lane, logic [1:0] sz);
        int unsigned n = 1 << sz;
        logic [7:0] s = '0;
        for (int unsigned i = 0; i < 8; i++)
            if (i >= lane && i < lane + n) s[i] = 1'b1;
        return s;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic compareAll();
        check("dreq_valid", dreq_valid, eDreqValid);
        check("stall_m", stall_m, eStall);
        check("out_valid", out_valid, eOutValid);
        check("out_regwrite", out_regwrite, eRegwrite);
        check("out_misalign", out_misalign, eMisalign);
        if (eDreqValid) begin
            check("dreq_addr", dreq_addr, eAddr);
            check("dreq_size", dreq_size, eSize);
            check("dreq_strobe", dreq_strobe, eStrobe);
            if (eDataChk) check("dreq_data", dreq_data, eData);
        end
        if (eOutValid) begin
            check("out_pc", out_pc, ePc);
            check("out_result", out_result, eResult);
            check("out_rd", out_rd, eRd);
        end
        if (stall_m === 1'b1) stallTotal++;
        if (out_valid === 1'b1) begin
            validTotal++;
            lastResult   = out_result;
            lastRegwrite = out_regwrite;
            lastMisalign = out_misalign;
        end
        if (dreq_valid === 1'b1) begin
            lastStrobe  = dreq_strobe;
            lastReqData = dreq_data;
            lastSize    = dreq_size;
        end
    endtask

    task automatic tick();
        @(negedge clk);
        if (chk) compareAll();
        @(posedge clk);
        #1;
    endtask

    task automatic clearExp();
        eDreqValid = 1'b0; eDataChk = 1'b0; eOutValid = 1'b0; eRegwrite = 1'b0;
        eMisalign = 1'b0; eStall = 1'b0;
        eAddr = '0; eData = '0; ePc = '0; eResult = '0; eSize = '0; eStrobe = '0; eRd = '0;
    endtask

    task automatic aluOp(input logic v, input logic mr, input logic [63:0] a,
                         input logic [4:0] rd, input logic rw, input logic ok);
        in_valid = v; in_pc = pc; in_alu = a; in_wdata = 64'h5555_AAAA;
        in_memread = mr; in_memwrite = 1'b0; in_funct3 = 3'b011; in_rd = rd; in_regwrite = rw;
        dresp_data_ok = ok; dresp_data = {$urandom, $urandom};
        clearExp();
        if (v) begin
            eOutValid = 1'b1; ePc = pc; eResult = a; eRd = rd; eRegwrite = rw && (rd != 0);
        end
        tick();
        dresp_data_ok = 1'b0;
        pc += 4;
    endtask

    task automatic memOp(input logic [2:0] f3, input logic wr, input logic [63:0] addr,
                         input logic [63:0] wdata, input logic [63:0] rdata,
                         input logic [4:0] rd, input logic rw, input int unsigned waits);
        int unsigned n = 1 << f3[1:0];
        in_valid = 1'b1; in_pc = pc; in_alu = addr; in_wdata = wdata;
        in_memread = !wr; in_memwrite = wr; in_funct3 = f3; in_rd = rd; in_regwrite = rw;
        dresp_data_ok = 1'b0; dresp_data = ~rdata;
        clearExp();
        if ((addr[2:0] % n) != 0) begin
            eOutValid = 1'b1; ePc = pc; eResult = addr; eRd = rd; eMisalign = 1'b1;
            tick();
        end else begin
            eDreqValid = 1'b1; eAddr = addr; eSize = {1'b0, f3[1:0]}; eStall = 1'b1;
            eStrobe  = wr ? refStrobe(addr[2:0], f3[1:0]) : 8'h00;
            eDataChk = wr;
            eData    = wdata << (8 * addr[2:0]);
            tick();
            for (int unsigned k = 1; k <= waits; k++) begin
                dresp_data_ok = (k == waits);
                dresp_data    = (k == waits) ? rdata : {$urandom, $urandom};
                tick();
            end
            dresp_data_ok = 1'b0; dresp_data = {$urandom, $urandom};
            clearExp();
            eOutValid = 1'b1; ePc = pc; eRd = rd;
            eResult   = wr ? addr : refLoad(rdata, addr[2:0], f3);
            eRegwrite = !wr && rw && (rd != 0);
            tick();
        end
        in_valid = 1'b0; in_memread = 1'b0; in_memwrite = 1'b0;
        clearExp();
        pc += 4;
    endtask

    initial begin
        int unsigned s0, v0;
        vecs[0] = '{3'b001, 1'b0, 64'h10A2, 64'h0, 64'h0000_0000_8001_0000, 5'd0, 1'b1, 1};
        vecs[1] = '{3'b101, 1'b0, 64'h10A6, 64'h0, 64'h1234_5678_9ABC_DEF0, 5'd3, 1'b1, 2};
        vecs[2] = '{3'b100, 1'b0, 64'h1007, 64'h0, 64'hFE00_0000_0000_0000, 5'd4, 1'b1, 1};
        vecs[3] = '{3'b011, 1'b0, 64'h2000, 64'h0, 64'hCAFE_F00D_DEAD_BEEF, 5'd6, 1'b1, 4};
        vecs[4] = '{3'b000, 1'b1, 64'h3005, 64'h1122_33AA, 64'h0, 5'd8, 1'b1, 1};
        vecs[5] = '{3'b010, 1'b1, 64'h3004, 64'hFFFF_0000_8765_4321, 64'h0, 5'd8, 1'b0, 2};
        vecs[6] = '{3'b011, 1'b1, 64'h3000, 64'h0102_0304_0506_0708, 64'h0, 5'd8, 1'b0, 1};
        vecs[7] = '{3'b010, 1'b1, 64'h3002, 64'h1, 64'h0, 5'd8, 1'b0, 1};
        vecs[8] = '{3'b001, 1'b0, 64'h1001, 64'h0, 64'h0, 5'd9, 1'b1, 1};

        reset = 1'b1; dresp_data_ok = 1'b0; dresp_data = '0;
        in_valid = 1'b1; in_pc = 64'h100; in_alu = 64'h77; in_wdata = '0;
        in_memread = 1'b0; in_memwrite = 1'b0; in_funct3 = '0; in_rd = 5'd1; in_regwrite = 1'b1;
        clearExp();
        chk = 1'b1;
        tick();
        tick();
        reset = 1'b0;

        // ADD passthrough
        aluOp(1'b1, 1'b0, 64'h1234, 5'd5, 1'b1, 1'b0);
        check("ADD result", lastResult, 64'h1234);
        check("ADD regwrite", lastRegwrite, 1'b1);

        // LB with response three cycles after issue
        s0 = stallTotal;
        memOp(3'b000, 1'b0, 64'h1003, 64'h0, 64'h0000_0000_8000_0000, 5'd10, 1'b1, 3);
        check("LB stall cycles", stallTotal - s0, 4);
        check("LB size", lastSize, 3'd0);
        check("LB strobe", lastStrobe, 8'h00);
        check("LB result", lastResult, 64'hFFFF_FFFF_FFFF_FF80);

        memOp(3'b110, 1'b0, 64'h2004, 64'h0, 64'h89AB_CDEF_0000_0000, 5'd11, 1'b1, 1);
        check("LWU result", lastResult, 64'h0000_0000_89AB_CDEF);
        memOp(3'b010, 1'b0, 64'h2004, 64'h0, 64'h89AB_CDEF_0000_0000, 5'd11, 1'b1, 1);
        check("LW result", lastResult, 64'hFFFF_FFFF_89AB_CDEF);

        memOp(3'b001, 1'b1, 64'h3006, 64'hBEEF, 64'h0, 5'd7, 1'b1, 5);
        check("SH strobe", lastStrobe, 8'hC0);
        check("SH data", lastReqData, 64'hBEEF_0000_0000_0000);
        check("SH regwrite", lastRegwrite, 1'b0);

        s0 = stallTotal;
        memOp(3'b011, 1'b0, 64'h4004, 64'h0, 64'h0, 5'd12, 1'b1, 1);
        check("LD misalign stall", stallTotal - s0, 0);
        check("LD misalign flag", lastMisalign, 1'b1);
        check("LD misalign regwrite", lastRegwrite, 1'b0);

        foreach (vecs[i])
            memOp(vecs[i].f3, vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].rdata,
                  vecs[i].rd, vecs[i].rw, vecs[i].waits);

        // Bubbles, rd==0 and a stray data_ok while idle
        aluOp(1'b0, 1'b1, 64'h5008, 5'd3, 1'b1, 1'b0);
        aluOp(1'b1, 1'b0, 64'hABCD, 5'd0, 1'b1, 1'b1);
        aluOp(1'b1, 1'b0, 64'h9999, 5'd31, 1'b0, 1'b0);

        // Reset while waiting; a late data_ok must not produce a DONE cycle
        in_valid = 1'b1; in_pc = pc; in_alu = 64'h5000; in_wdata = '0;
        in_memread = 1'b1; in_memwrite = 1'b0; in_funct3 = 3'b010; in_rd = 5'd9; in_regwrite = 1'b1;
        clearExp();
        eDreqValid = 1'b1; eAddr = 64'h5000; eSize = 3'd2; eStrobe = 8'h00; eStall = 1'b1;
        tick();
        tick();
        v0 = validTotal;
        reset = 1'b1; in_valid = 1'b0; in_memread = 1'b0;
        clearExp();
        tick();
        reset = 1'b0; dresp_data_ok = 1'b1; dresp_data = 64'hDEAD_BEEF_DEAD_BEEF;
        tick();
        dresp_data_ok = 1'b0;
        tick();
        tick();
        check("no DONE after reset", validTotal - v0, 0);
        aluOp(1'b1, 1'b0, 64'h4242, 5'd2, 1'b1, 1'b0);
        check("IDLE after reset", lastResult, 64'h4242);

        chk = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
